stopwatch_ctrl_p: RTL
=====================

// Module: stopwatch_ctrl_p
// PURPOSE
// - Parametrised stopwatch controller: run/pause/clear FSM plus integrated prescaler and up/down time counter.
// - Sits between the debounced button inputs and the display/BCD path; drives count, display value and status flags.
// - Adds over the previous controller: edge-detected start, countdown mode with preset, terminal-count DONE state, generic width/rate.
// PARAMETERS
// - CNT_W   16      width of count/preset/disp.
// - DIV     100000  clk cycles per count tick; >=1. Prescaler width is max(1,$clog2(DIV)).
// - MAX_CNT 9999    up-mode terminal count; must be < 2**CNT_W.
// PORTS
// - clk     in  1      clock; all state updates on the rising edge.
// - rst     in  1      reset rst, synchronous, active-high; priority over every other input.
// - start   in  1      debounced level; each rising edge toggles run/pause.
// - clear   in  1      level; while high, return to IDLE and reload.
// - down    in  1      mode select: 1 = countdown from preset, 0 = count up from 0. Used only in IDLE.
// - preset  in  CNT_W  countdown start value. Used only in IDLE.
// - lap     in  1      debounced level; rising edge toggles the display freeze (LAP_EN only).
// - count   out CNT_W  live counter value.
// - disp    out CNT_W  display value: count, or frozen lap value.
// - state   out 2      IDLE=00, RUN=01, PAUSE=10, DONE=11.
// - tick    out 1      one-cycle pulse on the cycle count changes.
// - done    out 1      high while state==DONE.
// BEHAVIOUR
// - Reset values: state=IDLE, count=0, prescaler=0, tick=0, done=0, disp=0, mode=up, lap hold cleared.
// - Edge detect: start_q<=start every cycle, including during rst.
//   - start_rise = start & ~start_q, so a button held through reset release does not start.
//   - lap is edge-detected the same way.
// - Priority within a cycle: rst > clear > terminal count > start_rise.
// - IDLE: each cycle, count <= (down ? preset : 0) and prescaler <= 0.
//   - On start_rise: latch down into mode; next state RUN.
//   - If down && preset==0 on start_rise: next state DONE instead.
// - RUN: prescaler increments each cycle.
//   - At prescaler==DIV-1: prescaler <= 0, tick=1 for one cycle, count +1 (up) or -1 (down).
//   - First tick occurs DIV cycles after the cycle in which state became RUN.
//   - Terminal: the tick that makes count==MAX_CNT (up) or count==0 (down) moves to DONE on the same edge. count never passes the terminal value; no wrap.
//   - start_rise -> PAUSE. prescaler is held, not cleared.
//   - start_rise coincident with a non-terminal tick: the tick is applied, then PAUSE.
// - PAUSE: count and prescaler frozen; tick=0. start_rise -> RUN and the prescaler resumes from its held value.
// - DONE: count frozen at the terminal value; done=1; start_rise ignored; only clear or rst leave it.
// - clear in any state: next state IDLE. count, prescaler and lap hold reloaded or cleared on the same edge.
// - A mode or preset change outside IDLE has no effect until the next IDLE.
// - tick is registered and aligned with the count update; done and state are registered.
// CONFIGURATION
// - Macro STOPWATCH_LAP_EN.
// - Defined: a lap rising edge in RUN or PAUSE toggles the hold flag.
//   - Setting the flag captures count into lap_reg; while the flag is set, disp=lap_reg.
//   - Clearing the flag returns disp to tracking count. The lap edge takes effect on the edge it is sampled; disp changes the following cycle.
//   - Lap edges in IDLE and DONE are ignored. clear and rst clear the hold flag.
// - Undefined: the lap port is present but ignored; no lap logic is synthesised; disp==count always.
// TESTING (DIV=4, MAX_CNT=5, CNT_W=8)
// - Up run: rst, down=0, start pulse -> state=01. tick every 4 cycles; count 1..5.
//   - On the 5th tick (20 cycles after RUN): state=11, done=1, count stays 5; further start pulses leave state=11.
// - Pause: start pulse after count=2 plus 1 prescaler cycle, hold 10 cycles -> count stays 2, tick=0.
//   - Second start pulse -> the next tick comes 3 cycles after resume; count=3.
// - Down: down=1, preset=3, start pulse -> count 2,1,0 at 4-cycle intervals, then DONE with count=0.
//   - With preset=0, a start pulse -> DONE the next cycle.
// - Priority: in RUN, clear and a start rising edge in the same cycle -> IDLE, count=0, prescaler=0.
//   - clear held in DONE -> IDLE, done=0.
// - Reset edge: start held high across rst deassert -> remains IDLE.
//   - Release start, then press -> RUN.
// - STOPWATCH_LAP_EN: lap pulse at count=2 -> disp=2 while count continues to 4; second lap pulse -> disp=4.
//   - Macro undefined: disp==count throughout.

Source files
------------

// File: rtl/stopwatch_ctrl_p_if.sv
// Stopwatch controller port bundle: button/mode inputs and count/status outputs.
// master = button/mode source, slave = stopwatch_ctrl_p.
interface stopwatch_ctrl_p_if #(
    parameter int unsigned CNT_W = 16
);
    logic             start;
    logic             clear;
    logic             down;
    logic [CNT_W-1:0] preset;
    logic             lap;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] disp;
    logic [1:0]       state;
    logic             tick;
    logic             done;

    modport master (
        output start, clear, down, preset, lap,
        input  count, disp, state, tick, done
    );

    modport slave (
        input  start, clear, down, preset, lap,
        output count, disp, state, tick, done
    );
endinterface

// File: rtl/stopwatch_ctrl_p.sv
// Stopwatch controller: run/pause/clear/done FSM with prescaler and up/down counter.
// Optional display lap-hold enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctrl_p #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned DIV     = 100000,
    parameter int unsigned MAX_CNT = 9999
) (
    input  logic               clk,
    input  logic               rst,
    stopwatch_ctrl_p_if.slave  bus
);
    localparam int unsigned PS_W = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t           r_state, w_nxt_state;
    logic [CNT_W-1:0] r_count, w_nxt_count;
    logic [CNT_W-1:0] r_disp,  w_nxt_disp;
    logic [PS_W-1:0]  r_ps,    w_nxt_ps;
    logic             r_tick,  w_nxt_tick;
    logic             r_mode,  w_nxt_mode;
    logic             r_done;
    logic             r_start_q;
    logic             w_start_rise;
    logic             w_ps_wrap;
    logic [CNT_W-1:0] w_step;
    logic [CNT_W-1:0] w_reload;
    logic [CNT_W-1:0] w_term;

    // Sampled through reset so a button held across reset release cannot start a run.
    always_ff @(posedge clk) begin
        r_start_q <= bus.start;
    end

    assign w_start_rise = bus.start & ~r_start_q;
    assign w_reload     = bus.down ? bus.preset : CNT_W'(0);
    assign w_ps_wrap    = (r_ps == PS_W'(DIV - 1));
    assign w_step       = r_mode ? (r_count - CNT_W'(1)) : (r_count + CNT_W'(1));
    assign w_term       = r_mode ? CNT_W'(0) : CNT_W'(MAX_CNT);

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_count = r_count;
        w_nxt_ps    = r_ps;
        w_nxt_tick  = 1'b0;
        w_nxt_mode  = r_mode;

        if (bus.clear) begin
            w_nxt_state = S_IDLE;
            w_nxt_count = w_reload;
            w_nxt_ps    = '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    w_nxt_count = w_reload;
                    w_nxt_ps    = '0;
                    if (w_start_rise) begin
                        w_nxt_mode  = bus.down;
                        w_nxt_state = (bus.down && (bus.preset == CNT_W'(0))) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    // A tick coinciding with a start edge is applied before pausing.
                    if (w_ps_wrap) begin
                        w_nxt_ps    = '0;
                        w_nxt_tick  = 1'b1;
                        w_nxt_count = w_step;
                        if (w_step == w_term) begin
                            w_nxt_state = S_DONE;
                        end else if (w_start_rise) begin
                            w_nxt_state = S_PAUSE;
                        end
                    end else begin
                        w_nxt_ps = r_ps + PS_W'(1);
                        if (w_start_rise) begin
                            w_nxt_state = S_PAUSE;
                        end
                    end
                end
                S_PAUSE: begin
                    if (w_start_rise) begin
                        w_nxt_state = S_RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic             r_lap_q;
    logic             r_hold, w_nxt_hold;
    logic [CNT_W-1:0] r_lap,  w_nxt_lap;
    logic             w_lap_rise;

    always_ff @(posedge clk) begin
        r_lap_q <= bus.lap;
    end

    assign w_lap_rise = bus.lap & ~r_lap_q;

    // Lap edge toggles the freeze; setting it snapshots the live count.
    always_comb begin
        w_nxt_hold = r_hold;
        w_nxt_lap  = r_lap;
        if (bus.clear) begin
            w_nxt_hold = 1'b0;
        end else if (w_lap_rise && ((r_state == S_RUN) || (r_state == S_PAUSE))) begin
            w_nxt_hold = ~r_hold;
            if (!r_hold) begin
                w_nxt_lap = r_count;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold <= 1'b0;
            r_lap  <= '0;
        end else begin
            r_hold <= w_nxt_hold;
            r_lap  <= w_nxt_lap;
        end
    end

    assign w_nxt_disp = w_nxt_hold ? w_nxt_lap : w_nxt_count;
`else
    assign w_nxt_disp = w_nxt_count;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_disp  <= '0;
            r_ps    <= '0;
            r_tick  <= 1'b0;
            r_mode  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_count <= w_nxt_count;
            r_disp  <= w_nxt_disp;
            r_ps    <= w_nxt_ps;
            r_tick  <= w_nxt_tick;
            r_mode  <= w_nxt_mode;
            r_done  <= (w_nxt_state == S_DONE);
        end
    end

    assign bus.count = r_count;
    assign bus.disp  = r_disp;
    assign bus.state = r_state;
    assign bus.tick  = r_tick;
    assign bus.done  = r_done;
endmodule
